// File: rtl/rca_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rca_seq_ctrl_pkg
// Shared types and defaults for the sequential ripple-carry adder controller.
//   state_t   : controller FSM state
//   DEF_WIDTH : default operand/result width
//   DEF_SLICE : default adder slice width
//   req_id_t  : requester identifier (two requesters)
// ---------------------------------------------------------------------------
package rca_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SLICE = 4;

    typedef logic req_id_t;

endpackage

// File: rtl/rca_seq_ctrl_slice_adder.sv
// ---------------------------------------------------------------------------
// slice_adder
// SLICE-bit combinational ripple-carry adder, reused every RUN cycle.
//   a, b : slice operands
//   cin  : carry into bit 0
//   sum  : slice sum
//   cout : carry out of the top bit
// ---------------------------------------------------------------------------
module slice_adder #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout
);

    logic [SLICE:0] w_c;

    always_comb begin
        w_c    = '0;
        sum    = '0;
        w_c[0] = cin;
        for (int i = 0; i < SLICE; i++) begin
            sum[i]   = a[i] ^ b[i] ^ w_c[i];
            w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = w_c[SLICE];

endmodule

// File: rtl/rca_seq_ctrl.sv
// ---------------------------------------------------------------------------
// rca_seq_ctrl
// Two-requester round-robin front end for a slice-serial ripple-carry adder.
// One SLICE-bit adder processes WIDTH/SLICE slices on consecutive cycles.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : per-requester handshake (ready only in IDLE)
//   req_a, req_b        : packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_cin             : per-requester carry-in
//   resp_valid/ready    : result handshake, result held until accepted
//   resp_id/sum/cout/ovf: owner, sum, unsigned carry, signed overflow
//   busy                : controller not in IDLE
// ---------------------------------------------------------------------------
module rca_seq_ctrl
    import rca_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*WIDTH-1:0] req_a,
    input  logic [2*WIDTH-1:0] req_b,
    input  logic [1:0]         req_cin,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic               resp_id,
    output logic [WIDTH-1:0]   resp_sum,
    output logic               resp_cout,
    output logic               resp_ovf,
    output logic               busy
);

    localparam int NSL   = WIDTH / SLICE;
    localparam int CNT_W = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSL - 1);

    state_t               r_state;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_sum;
    logic                 r_carry;
    logic [CNT_W-1:0]     r_cnt;
    req_id_t              r_id;
    req_id_t              r_last;
    logic                 r_resp_valid;
    req_id_t              r_resp_id;
    logic [WIDTH-1:0]     r_resp_sum;
    logic                 r_resp_cout;
    logic                 r_resp_ovf;

    logic [SLICE-1:0]       w_slice_sum;
    logic                   w_slice_cout;
    logic [WIDTH+SLICE-1:0] w_sum_shift;
    logic [WIDTH-1:0]       w_sum_next;
    logic                   w_msb_cin;
    logic [1:0]             w_grant;
    req_id_t                w_grant_id;
    logic                   w_accept;

    // Operands shift right one slice per cycle, so the adder always sees
    // the low slice; no variable part-select is needed.
    slice_adder #(.SLICE(SLICE)) u_slice_adder (
        .a    (r_a[SLICE-1:0]),
        .b    (r_b[SLICE-1:0]),
        .cin  (r_carry),
        .sum  (w_slice_sum),
        .cout (w_slice_cout)
    );

    // Slice sums enter at the top and shift down; after NSL cycles the
    // first slice sits at bit 0.
    assign w_sum_shift = {w_slice_sum, r_sum};
    assign w_sum_next  = w_sum_shift[WIDTH+SLICE-1:SLICE];

    // Carry into the operand MSB recovered from the top slice's MSB bits.
    assign w_msb_cin = r_a[SLICE-1] ^ r_b[SLICE-1] ^ w_slice_sum[SLICE-1];

    // Round-robin: on a tie the requester not granted last wins.
    assign w_grant[0] = req_valid[0] && (!req_valid[1] || (r_last == 1'b1));
    assign w_grant[1] = req_valid[1] && (!req_valid[0] || (r_last == 1'b0));
    assign w_grant_id = w_grant[1];
    assign w_accept   = (r_state == IDLE) && (w_grant != 2'b00);

    // Gated by rst_n so the strobe is also low while reset is asserted.
    assign req_ready  = (rst_n && (r_state == IDLE)) ? w_grant : 2'b00;
    assign busy       = (r_state != IDLE);

    assign resp_valid = r_resp_valid;
    assign resp_id    = r_resp_id;
    assign resp_sum   = r_resp_sum;
    assign resp_cout  = r_resp_cout;
    assign resp_ovf   = r_resp_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_sum        <= '0;
            r_carry      <= 1'b0;
            r_cnt        <= '0;
            r_id         <= 1'b0;
            r_last       <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_id    <= 1'b0;
            r_resp_sum   <= '0;
            r_resp_cout  <= 1'b0;
            r_resp_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= w_grant_id ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
                        r_b     <= w_grant_id ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
                        r_carry <= req_cin[w_grant_id];
                        r_id    <= w_grant_id;
                        r_last  <= w_grant_id;
                        r_sum   <= '0;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> SLICE;
                    r_b     <= r_b >> SLICE;
                    r_sum   <= w_sum_next;
                    r_carry <= w_slice_cout;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_SLICE) begin
                        r_state      <= DONE;
                        r_resp_valid <= 1'b1;
                        r_resp_id    <= r_id;
                        r_resp_sum   <= w_sum_next;
                        r_resp_cout  <= w_slice_cout;
                        r_resp_ovf   <= w_msb_cin ^ w_slice_cout;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        r_state      <= IDLE;
                        r_resp_valid <= 1'b0;
                        r_resp_id    <= 1'b0;
                        r_resp_sum   <= '0;
                        r_resp_cout  <= 1'b0;
                        r_resp_ovf   <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rca_seq_ctrl.sv
module tb_rca_seq_ctrl;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [2*W-1:0] req_a;
    logic [2*W-1:0] req_b;
    logic [1:0]     req_cin;
    logic           resp_valid;
    logic           resp_ready;
    logic           resp_id;
    logic [W-1:0]   resp_sum;
    logic           resp_cout;
    logic           resp_ovf;
    logic           busy;

    always #5 clk = ~clk;

    rca_seq_ctrl #(.WIDTH(W), .SLICE(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_cin    (req_cin),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_sum   (resp_sum),
        .resp_cout  (resp_cout),
        .resp_ovf   (resp_ovf),
        .busy       (busy)
    );

    typedef struct {
        logic         id;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    logic grants[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin);
        logic [W:0] f;
        exp_t       e;
        f      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        e.id   = id;
        e.sum  = f[W-1:0];
        e.cout = f[W];
        e.ovf  = (a[W-1] == b[W-1]) && (e.sum[W-1] != a[W-1]);
        return e;
    endfunction

    // Scoreboard: push on observed accept, pop on observed result handshake.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                if (req_ready[i]) begin
                    sb.push_back(model(i[0], req_a[i*W +: W], req_b[i*W +: W], req_cin[i]));
                    grants.push_back(i[0]);
                end
            end
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("resp_id",   {31'd0, resp_id},   {31'd0, e.id});
                    check("resp_sum",  {16'd0, resp_sum},  {16'd0, e.sum});
                    check("resp_cout", {31'd0, resp_cout}, {31'd0, e.cout});
                    check("resp_ovf",  {31'd0, resp_ovf},  {31'd0, e.ovf});
                end
            end
            if (!resp_valid)
                check("resp_idle_zero", {12'd0, resp_id, resp_cout, resp_ovf, resp_sum}, 32'd0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        bit got;
        got = 1'b0;
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        req_cin[id]      = cin;
        req_valid[id]    = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        while (!resp_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 60; t++) begin
            if (sb.size() == 0 && !busy) break;
            @(posedge clk);
            #1;
        end
        check("drain", {31'd0, (sb.size() == 0 && !busy)}, 32'd1);
    endtask

    initial begin
        int   n;
        exp_t e;

        rst_n      = 1'b0;
        req_valid  = 2'b11;
        req_a      = '0;
        req_b      = '0;
        req_cin    = 2'b00;
        resp_ready = 1'b1;
        tick(2);
        check("rst_busy",       {31'd0, busy},       32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_req_ready",  {30'd0, req_ready},  32'd0);
        check("rst_resp_sum",   {16'd0, resp_sum},   32'd0);
        req_valid = 2'b00;
        rst_n     = 1'b1;
        tick(1);

        // Directed vectors with fixed expected results and latency.
        drive(0, 16'h1234, 16'h0FFF, 1'b0);
        wait_resp(n);
        check("latency_t1", n, 32'd4);
        check("t1_sum",  {16'd0, resp_sum}, 32'h2233);
        check("t1_cout", {31'd0, resp_cout}, 32'd0);
        check("t1_ovf",  {31'd0, resp_ovf},  32'd0);
        check("t1_id",   {31'd0, resp_id},   32'd0);
        wait_idle();

        drive(1, 16'hFFFF, 16'h0001, 1'b0);
        wait_resp(n);
        check("latency_t2", n, 32'd4);
        check("t2_sum",  {16'd0, resp_sum}, 32'h0000);
        check("t2_cout", {31'd0, resp_cout}, 32'd1);
        check("t2_ovf",  {31'd0, resp_ovf},  32'd0);
        check("t2_id",   {31'd0, resp_id},   32'd1);
        wait_idle();

        drive(0, 16'h7FFF, 16'h0000, 1'b1);
        wait_resp(n);
        check("t3_sum",  {16'd0, resp_sum}, 32'h8000);
        check("t3_cout", {31'd0, resp_cout}, 32'd0);
        check("t3_ovf",  {31'd0, resp_ovf},  32'd1);
        wait_idle();

        // Both requesters held valid from reset: grants must alternate.
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        grants.delete();
        req_a     = {$urandom, $urandom};
        req_b     = {$urandom, $urandom};
        req_cin   = 2'($urandom);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            for (int t = 0; t < 40 && grants.size() <= k; t++) @(negedge clk);
            @(posedge clk);
            #1;
            // Operands change while the accepted operation is in flight.
            req_a   = {$urandom, $urandom};
            req_b   = {$urandom, $urandom};
            req_cin = 2'($urandom);
            if (k == 3) req_valid = 2'b00;
        end
        wait_idle();
        check("rr_count", grants.size(), 32'd4);
        for (int k = 0; k < 4 && k < grants.size(); k++)
            check("rr_order", {31'd0, grants[k]}, k % 2);

        // Consumer stall in DONE.
        resp_ready = 1'b0;
        drive(1, 16'($urandom), 16'($urandom), 1'($urandom));
        wait_resp(n);
        check("stall_reach_done", {31'd0, resp_valid}, 32'd1);
        e         = sb[0];
        req_valid = 2'b11;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("stall_valid",     {31'd0, resp_valid}, 32'd1);
            check("stall_sum",       {16'd0, resp_sum},   {16'd0, e.sum});
            check("stall_req_ready", {30'd0, req_ready},  32'd0);
        end
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        check("release_idle",  {31'd0, busy},       32'd0);
        check("release_valid", {31'd0, resp_valid}, 32'd0);
        wait_idle();

        // Reset in the middle of RUN discards the transaction.
        drive(0, 16'hA5A5, 16'h5A5A, 1'b1);
        tick(2);
        rst_n = 1'b0;
        #1;
        check("midrst_busy",      {31'd0, busy},       32'd0);
        check("midrst_valid",     {31'd0, resp_valid}, 32'd0);
        check("midrst_sum",       {16'd0, resp_sum},   32'd0);
        check("midrst_req_ready", {30'd0, req_ready},  32'd0);
        sb.delete();
        tick(1);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("midrst_no_resp", {31'd0, resp_valid}, 32'd0);
        end
        drive(1, 16'h8000, 16'h8000, 1'b0);
        wait_resp(n);
        check("post_rst_latency", n, 32'd4);
        wait_idle();

        // Random single requests.
        for (int r = 0; r < 8; r++) begin
            drive(int'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 1'($urandom));
            wait_idle();
        end

        check("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
